// File: rtl/sc_job_sequencer.sv
// Multi-job sequencer: queues descriptors, runs each job through fetch -> sort -> return
// (or fetch -> return in copy mode), and reports per-job status through a completion FIFO.
module sc_job_sequencer #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 1024,
    parameter int PASID_WIDTH    = 9,
    parameter int BEAT_WIDTH     = 6,
    parameter int JOBID_WIDTH    = 16,
    parameter int RETURN_WIDTH   = 64,
    parameter int DESC_DEPTH     = 4,
    parameter int CPL_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    engine_start,
    output logic                    engine_ready,
    input  logic [DATA_WIDTH-1:0]   engine_data,
    output logic                    complete_ready,
    input  logic                    complete_accept,
    output logic [RETURN_WIDTH-1:0] complete_data,
    output logic                    fetch_start,
    output logic                    sort_start,
    output logic                    return_start,
    input  logic                    fetch_done,
    input  logic                    sort_done,
    input  logic                    return_done,
    output logic [ADDR_WIDTH-1:0]   fetch_start_addr,
    output logic [ADDR_WIDTH-1:0]   return_start_addr,
    output logic [PASID_WIDTH-1:0]  fetch_pasid,
    output logic [PASID_WIDTH-1:0]  return_pasid,
    output logic [BEAT_WIDTH-1:0]   fetch_beat_num,
    output logic [BEAT_WIDTH-1:0]   return_beat_num,
    output logic                    bypass_sel,
    output logic                    busy,
    output logic                    engine_error
);
    localparam int DESC_W = 2*ADDR_WIDTH + BEAT_WIDTH + PASID_WIDTH + JOBID_WIDTH + 1;
    localparam int RA_LSB = ADDR_WIDTH;
    localparam int BN_LSB = 2*ADDR_WIDTH;
    localparam int PA_LSB = BN_LSB + BEAT_WIDTH;
    localparam int ID_LSB = PA_LSB + PASID_WIDTH;
    localparam int BY_LSB = ID_LSB + JOBID_WIDTH;
    localparam int DAW    = $clog2(DESC_DEPTH);
    localparam int CAW    = $clog2(CPL_DEPTH);
    localparam int PCW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [PCW-1:0] PHASE_LAST = PCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0] ST_OK = 2'd0, ST_TIMEOUT = 2'd1, ST_BADLEN = 2'd2;

    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, SORT = 3'd2, RETURN = 3'd3, CPL = 3'd4} state_t;

    state_t                  state, state_next;
    logic [1:0]              status, status_next;
    logic [PCW-1:0]          phase_cnt;
    logic [31:0]             cyc_cnt;
    logic [ADDR_WIDTH-1:0]   job_faddr, job_raddr;
    logic [BEAT_WIDTH-1:0]   job_beats;
    logic [PASID_WIDTH-1:0]  job_pasid;
    logic [JOBID_WIDTH-1:0]  job_id;
    logic                    job_bypass;
    logic                    timeout_hit, in_phase;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high
    // (engine_start/engine_ready for descriptors, complete_ready/complete_accept for completions).
    logic [DESC_W-1:0]       desc_mem [DESC_DEPTH];
    logic [DAW:0]            desc_wr_ptr, desc_rd_ptr;
    logic [DESC_W-1:0]       desc_head;
    logic                    desc_empty, desc_full, desc_push, desc_pop, init_done;
    logic                    unused_data_bits;

    assign desc_empty   = (desc_wr_ptr == desc_rd_ptr);
    assign desc_full    = (desc_wr_ptr[DAW] != desc_rd_ptr[DAW]) &&
                          (desc_wr_ptr[DAW-1:0] == desc_rd_ptr[DAW-1:0]);
    assign engine_ready = init_done && !desc_full;
    assign desc_push    = engine_start && engine_ready;
    assign desc_pop     = (state == IDLE) && !desc_empty;
    assign desc_head    = desc_mem[desc_rd_ptr[DAW-1:0]];
    assign unused_data_bits = ^engine_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_wr_ptr <= '0;
            desc_rd_ptr <= '0;
            init_done   <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (desc_push) desc_wr_ptr <= desc_wr_ptr + 1'b1;
            if (desc_pop)  desc_rd_ptr <= desc_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (desc_push) desc_mem[desc_wr_ptr[DAW-1:0]] <= engine_data[DESC_W-1:0];
    end

    // Completion FIFO
    logic [RETURN_WIDTH-1:0] cpl_mem [CPL_DEPTH];
    logic [CAW:0]            cpl_wr_ptr, cpl_rd_ptr;
    logic [RETURN_WIDTH-1:0] cpl_word;
    logic                    cpl_empty, cpl_full, cpl_push, cpl_pop;

    assign cpl_empty      = (cpl_wr_ptr == cpl_rd_ptr);
    assign cpl_full       = (cpl_wr_ptr[CAW] != cpl_rd_ptr[CAW]) &&
                            (cpl_wr_ptr[CAW-1:0] == cpl_rd_ptr[CAW-1:0]);
    assign cpl_push       = (state == CPL) && !cpl_full;
    assign complete_ready = !cpl_empty;
    assign cpl_pop        = complete_ready && complete_accept;
    assign complete_data  = cpl_empty ? '0 : cpl_mem[cpl_rd_ptr[CAW-1:0]];

    always_comb begin
        cpl_word = '0;
        cpl_word[JOBID_WIDTH-1:0]       = job_id;
        cpl_word[JOBID_WIDTH +: 2]      = status;
        cpl_word[RETURN_WIDTH-1 -: 32]  = cyc_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpl_wr_ptr <= '0;
            cpl_rd_ptr <= '0;
        end else begin
            if (cpl_push) cpl_wr_ptr <= cpl_wr_ptr + 1'b1;
            if (cpl_pop)  cpl_rd_ptr <= cpl_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cpl_push) cpl_mem[cpl_wr_ptr[CAW-1:0]] <= cpl_word;
    end

    // Timeout fires on the last allowed cycle of a phase; done is checked first so it wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (phase_cnt == PHASE_LAST);
    assign in_phase    = (state == FETCH) || (state == SORT) || (state == RETURN);

    always_comb begin
        state_next  = state;
        status_next = status;
        case (state)
            IDLE: begin
                if (!desc_empty) begin
                    if (desc_head[BN_LSB +: BEAT_WIDTH] == '0) begin
                        state_next  = CPL;
                        status_next = ST_BADLEN;
                    end else begin
                        state_next  = FETCH;
                        status_next = ST_OK;
                    end
                end
            end
            FETCH: begin
                if (fetch_done)       state_next = job_bypass ? RETURN : SORT;
                else if (timeout_hit) begin state_next = CPL; status_next = ST_TIMEOUT; end
            end
            SORT: begin
                if (sort_done)        state_next = RETURN;
                else if (timeout_hit) begin state_next = CPL; status_next = ST_TIMEOUT; end
            end
            RETURN: begin
                if (return_done)      begin state_next = CPL; status_next = ST_OK; end
                else if (timeout_hit) begin state_next = CPL; status_next = ST_TIMEOUT; end
            end
            CPL: begin
                if (!cpl_full) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            status       <= ST_OK;
            phase_cnt    <= '0;
            cyc_cnt      <= '0;
            job_faddr    <= '0;
            job_raddr    <= '0;
            job_beats    <= '0;
            job_pasid    <= '0;
            job_id       <= '0;
            job_bypass   <= 1'b0;
            engine_error <= 1'b0;
        end else begin
            state  <= state_next;
            status <= status_next;
            if (state_next != state)  phase_cnt <= '0;
            else if (phase_cnt != '1) phase_cnt <= phase_cnt + PCW'(1);
            if (desc_pop) begin
                job_faddr  <= desc_head[0 +: ADDR_WIDTH];
                job_raddr  <= desc_head[RA_LSB +: ADDR_WIDTH];
                job_beats  <= desc_head[BN_LSB +: BEAT_WIDTH];
                job_pasid  <= desc_head[PA_LSB +: PASID_WIDTH];
                job_id     <= desc_head[ID_LSB +: JOBID_WIDTH];
                job_bypass <= desc_head[BY_LSB];
                cyc_cnt    <= '0;
            end else if (in_phase && cyc_cnt != 32'hFFFF_FFFF) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (cpl_push && status != ST_OK) engine_error <= 1'b1;
        end
    end

    // Start pulses mark the first cycle of each phase (phase counter saturates, never wraps).
    assign busy              = (state != IDLE);
    assign fetch_start       = (state == FETCH)  && (phase_cnt == '0);
    assign sort_start        = (state == SORT)   && (phase_cnt == '0);
    assign return_start      = (state == RETURN) && (phase_cnt == '0);
    assign fetch_start_addr  = job_faddr;
    assign return_start_addr = job_raddr;
    assign fetch_pasid       = job_pasid;
    assign return_pasid      = job_pasid;
    assign fetch_beat_num    = job_beats;
    assign return_beat_num   = job_beats;
    assign bypass_sel        = job_bypass;
endmodule

// File: tb/tb_sc_job_sequencer.sv
// Directed bench for sc_job_sequencer: vector table of single jobs plus hand-written
// sequences for descriptor backpressure, completion stall, stray done pulses and reset.
module tb_sc_job_sequencer;
    localparam int AW = 64, DW = 1024, PW = 9, BW = 6, JW = 16, RW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          engine_start, engine_ready, complete_ready, complete_accept;
    logic [DW-1:0] engine_data;
    logic [RW-1:0] complete_data;
    logic          fetch_start, sort_start, return_start;
    logic          fetch_done, sort_done, return_done;
    logic [AW-1:0] fetch_start_addr, return_start_addr;
    logic [PW-1:0] fetch_pasid, return_pasid;
    logic [BW-1:0] fetch_beat_num, return_beat_num;
    logic          bypass_sel, busy, engine_error;

    always #5 clk = ~clk;

    sc_job_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PASID_WIDTH(PW), .BEAT_WIDTH(BW),
        .JOBID_WIDTH(JW), .RETURN_WIDTH(RW), .DESC_DEPTH(4), .CPL_DEPTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .engine_start(engine_start), .engine_ready(engine_ready), .engine_data(engine_data),
        .complete_ready(complete_ready), .complete_accept(complete_accept),
        .complete_data(complete_data),
        .fetch_start(fetch_start), .sort_start(sort_start), .return_start(return_start),
        .fetch_done(fetch_done), .sort_done(sort_done), .return_done(return_done),
        .fetch_start_addr(fetch_start_addr), .return_start_addr(return_start_addr),
        .fetch_pasid(fetch_pasid), .return_pasid(return_pasid),
        .fetch_beat_num(fetch_beat_num), .return_beat_num(return_beat_num),
        .bypass_sel(bypass_sel), .busy(busy), .engine_error(engine_error)
    );

    int            total = 0;
    int            bad = 0;
    logic [RW-1:0] exp_q[$];
    int            fetch_cnt = 0, sort_cnt = 0, ret_cnt = 0;
    int            done_dly = 5;
    bit            withhold_all = 1'b0, withhold_sort = 1'b0;

    typedef struct {
        logic [15:0] id;
        logic [5:0]  beats;
        logic        byp;
        int          dly;
        bit          hold_sort;
        logic [63:0] src;
        logic [63:0] dst;
        logic [8:0]  pasid;
        logic [1:0]  st;
        logic [31:0] cnt;
        int          nf;
        int          ns;
        int          nr;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(logic [15:0] id, logic [5:0] beats, logic byp, int dly, bit hs,
                                logic [63:0] src, logic [63:0] dst, logic [8:0] pasid,
                                logic [1:0] st, logic [31:0] cnt, int nf, int ns, int nr);
        vec_t v;
        v.id = id; v.beats = beats; v.byp = byp; v.dly = dly; v.hold_sort = hs;
        v.src = src; v.dst = dst; v.pasid = pasid; v.st = st; v.cnt = cnt;
        v.nf = nf; v.ns = ns; v.nr = nr;
        return v;
    endfunction

    function automatic logic [63:0] exp_word(logic [15:0] id, logic [1:0] st, logic [31:0] cnt);
        return {cnt, 14'd0, st, id};
    endfunction

    // Sub-block models: answer each start pulse with a done pulse done_dly cycles later.
    initial begin
        fetch_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fetch_start) begin
                fetch_cnt++;
                if (!withhold_all) begin
                    repeat (done_dly) @(posedge clk);
                    #1 fetch_done = 1'b1;
                    @(posedge clk); #1 fetch_done = 1'b0;
                end
            end
        end
    end

    initial begin
        sort_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (sort_start) begin
                sort_cnt++;
                if (!withhold_all && !withhold_sort) begin
                    repeat (done_dly) @(posedge clk);
                    #1 sort_done = 1'b1;
                    @(posedge clk); #1 sort_done = 1'b0;
                end
            end
        end
    end

    initial begin
        return_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (return_start) begin
                ret_cnt++;
                if (!withhold_all) begin
                    repeat (done_dly) @(posedge clk);
                    #1 return_done = 1'b1;
                    @(posedge clk); #1 return_done = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_desc(input logic [15:0] id, input logic [5:0] beats, input logic byp,
                             input logic [63:0] src, input logic [63:0] dst, input logic [8:0] pasid);
        logic [DW-1:0] d;
        bit            sent;
        d = '0;
        d[63:0] = src;
        d[127:64] = dst;
        d[133:128] = beats;
        d[142:134] = pasid;
        d[158:143] = id;
        d[159] = byp;
        d[200] = 1'b1;
        d[DW-1] = 1'b1;
        engine_data = d;
        engine_start = 1'b1;
        sent = 1'b0;
        for (int c = 0; c < 200 && !sent; c++) begin
            if (engine_ready) sent = 1'b1;
            @(posedge clk); #1;
        end
        engine_start = 1'b0;
        if (!sent) begin
            total++; bad++;
            $display("FAIL push_timeout id=%0h: got no engine_ready, expected ready within 200 cycles", id);
        end
    endtask

    task automatic pop_check(input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            if (complete_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s_timeout: got complete_ready=0, expected 1 within 400 cycles", name);
        end else if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_extra: got completion %0h, expected none", name, complete_data);
        end else begin
            chk(name, complete_data, exp_q.pop_front());
            complete_accept = 1'b1;
            @(posedge clk); #1 complete_accept = 1'b0;
        end
    endtask

    task automatic wait_cnt_one(input string name, input int which);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if ((which == 0 && fetch_cnt >= 1) || (which == 2 && ret_cnt >= 1)) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: got no start pulse, expected one within 200 cycles", name);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, expected finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        bit   exp_err;
        engine_start = 1'b0;
        engine_data = '0;
        complete_accept = 1'b0;
        exp_err = 1'b0;

        vecs[0] = mk(16'h0011, 6'd4,  1'b0, 5,  1'b0, 64'h1000, 64'h2000, 9'h005, 2'd0, 32'd18, 1, 1, 1);
        vecs[1] = mk(16'h0022, 6'd8,  1'b1, 5,  1'b0, 64'h3000, 64'h4000, 9'h1ab, 2'd0, 32'd12, 1, 0, 1);
        vecs[2] = mk(16'h0033, 6'd0,  1'b0, 5,  1'b0, 64'h5000, 64'h6000, 9'h0f0, 2'd2, 32'd0,  0, 0, 0);
        vecs[3] = mk(16'h0044, 6'd63, 1'b0, 5,  1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h7000, 9'h1ff, 2'd1, 32'd22, 1, 1, 0);
        vecs[4] = mk(16'h0055, 6'd1,  1'b0, 1,  1'b0, 64'h8000, 64'h9000, 9'h011, 2'd0, 32'd6,  1, 1, 1);
        vecs[5] = mk(16'h0066, 6'd2,  1'b1, 0,  1'b0, 64'hA000, 64'hB000, 9'h022, 2'd0, 32'd2,  1, 0, 1);
        vecs[6] = mk(16'h0077, 6'd3,  1'b1, 15, 1'b0, 64'hC000, 64'hD000, 9'h033, 2'd0, 32'd32, 1, 0, 1);
        vecs[7] = mk(16'h0088, 6'd5,  1'b0, 16, 1'b0, 64'hE000, 64'hF000, 9'h044, 2'd1, 32'd16, 1, 0, 0);
        vecs[8] = mk(16'hFFFF, 6'd7,  1'b0, 3,  1'b0, 64'h1_0000, 64'h2_0000, 9'h155, 2'd0, 32'd12, 1, 1, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_engine_ready", engine_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_complete_ready", complete_ready, 0);
        chk("rst_complete_data", complete_data, 0);
        chk("rst_engine_error", engine_error, 0);
        chk("rst_fetch_start", fetch_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_first_edge", engine_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_release", engine_ready, 1);

        // Single-job vector table
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            fetch_cnt = 0; sort_cnt = 0; ret_cnt = 0;
            done_dly = v.dly;
            withhold_sort = v.hold_sort;
            exp_q.push_back(exp_word(v.id, v.st, v.cnt));
            push_desc(v.id, v.beats, v.byp, v.src, v.dst, v.pasid);
            pop_check($sformatf("cpl_word_%0d", i));
            if (v.st != 2'd0) exp_err = 1'b1;
            chk($sformatf("fetch_starts_%0d", i), fetch_cnt, v.nf);
            chk($sformatf("sort_starts_%0d", i), sort_cnt, v.ns);
            chk($sformatf("return_starts_%0d", i), ret_cnt, v.nr);
            chk($sformatf("fetch_addr_%0d", i), fetch_start_addr, v.src);
            chk($sformatf("return_addr_%0d", i), return_start_addr, v.dst);
            chk($sformatf("pasid_%0d", i), {return_pasid, fetch_pasid}, {v.pasid, v.pasid});
            chk($sformatf("beats_%0d", i), {return_beat_num, fetch_beat_num}, {v.beats, v.beats});
            chk($sformatf("bypass_sel_%0d", i), bypass_sel, v.byp);
            chk($sformatf("busy_idle_%0d", i), busy, 0);
            chk($sformatf("engine_error_%0d", i), engine_error, exp_err);
        end
        withhold_sort = 1'b0;

        // Stray done pulses while idle are ignored
        fetch_cnt = 0; sort_cnt = 0; ret_cnt = 0;
        sort_done = 1'b1;   @(posedge clk); #1 sort_done = 1'b0;
        fetch_done = 1'b1;  @(posedge clk); #1 fetch_done = 1'b0;
        return_done = 1'b1; @(posedge clk); #1 return_done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stray_busy", busy, 0);
        chk("stray_complete_ready", complete_ready, 0);
        chk("stray_starts", fetch_cnt + sort_cnt + ret_cnt, 0);

        // Descriptor FIFO backpressure: blocker job times out in FETCH while 5 more are pushed
        withhold_all = 1'b1;
        fetch_cnt = 0;
        exp_q.push_back(exp_word(16'h00A0, 2'd1, 32'd16));
        push_desc(16'h00A0, 6'd4, 1'b0, 64'h100, 64'h200, 9'h001);
        wait_cnt_one("blocker_fetch_start", 0);
        withhold_all = 1'b0;
        done_dly = 2;
        for (int j = 1; j <= 4; j++) begin
            exp_q.push_back(exp_word(16'h00B0 + 16'(j), 2'd0, 32'd9));
            push_desc(16'h00B0 + 16'(j), 6'd2, 1'b0, 64'h300, 64'h400, 9'h002);
        end
        chk("desc_full_ready_low", engine_ready, 0);
        chk("desc_full_busy", busy, 1);
        exp_q.push_back(exp_word(16'h00B5, 2'd0, 32'd9));
        push_desc(16'h00B5, 6'd2, 1'b0, 64'h300, 64'h400, 9'h002);
        for (int j = 0; j < 6; j++) pop_check($sformatf("fifo_order_%0d", j));

        // Completion FIFO stall: 4 completions queue, 5th job waits in CPL
        done_dly = 1;
        for (int j = 1; j <= 5; j++) begin
            exp_q.push_back(exp_word(16'h00C0 + 16'(j), 2'd0, 32'd6));
            push_desc(16'h00C0 + 16'(j), 6'd1, 1'b0, 64'h500, 64'h600, 9'h003);
        end
        repeat (60) @(posedge clk);
        #1;
        chk("cpl_stall_busy", busy, 1);
        chk("cpl_stall_complete_ready", complete_ready, 1);
        chk("cpl_stall_engine_ready", engine_ready, 1);
        pop_check("cpl_stall_pop_0");
        chk("cpl_still_stalled", busy, 1);
        @(posedge clk); #1;
        chk("cpl_push_resumed", busy, 0);
        for (int j = 1; j < 5; j++) pop_check($sformatf("cpl_stall_pop_%0d", j));

        // Reset in the middle of RETURN with both FIFOs non-empty
        done_dly = 1;
        push_desc(16'h00D1, 6'd1, 1'b0, 64'h700, 64'h800, 9'h004);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                if (complete_ready) seen = 1'b1;
                else begin @(posedge clk); #1; end
            end
            chk("rst_seq_cpl_queued", complete_ready, 1);
        end
        done_dly = 10;
        ret_cnt = 0;
        push_desc(16'h00D2, 6'd3, 1'b1, 64'h900, 64'hA00, 9'h005);
        wait_cnt_one("rst_seq_return_start", 2);
        push_desc(16'h00D3, 6'd3, 1'b0, 64'hB00, 64'hC00, 9'h006);
        chk("rst_seq_busy_before", busy, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_engine_ready", engine_ready, 0);
        chk("midrst_complete_ready", complete_ready, 0);
        chk("midrst_complete_data", complete_data, 0);
        chk("midrst_engine_error", engine_error, 0);
        chk("midrst_bypass_sel", bypass_sel, 0);
        chk("midrst_addrs", fetch_start_addr | return_start_addr, 0);
        chk("midrst_starts", {fetch_start, sort_start, return_start}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_cnt = 0; sort_cnt = 0; ret_cnt = 0;
        repeat (30) @(posedge clk);
        #1;
        chk("postrst_no_starts", fetch_cnt + sort_cnt + ret_cnt, 0);
        chk("postrst_busy", busy, 0);
        chk("postrst_cpl_empty", complete_ready, 0);
        chk("postrst_engine_ready", engine_ready, 1);
        chk("postrst_engine_error", engine_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
